// File: rtl/sr_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : sr_instr_encoder
//  Purpose  : Encodes abstract instruction requests (op, rd, rs1, rs2, imm)
//             into RV32I words and streams them into instruction memory at an
//             auto-incrementing word address. Used to preload imem.
//  Revision : 1.0  initial release
// ============================================================================
module sr_instr_encoder #(
    parameter int ADDR_WIDTH = 5,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [31:0]           req_imm,
    input  logic                  req_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH:0]   count
);

    // Load-sequencer states
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;
    localparam logic [1:0] c_err  = 2'd3;

    // Request op codes
    localparam logic [3:0] c_reqAdd  = 4'd0;
    localparam logic [3:0] c_reqOr   = 4'd1;
    localparam logic [3:0] c_reqSrl  = 4'd2;
    localparam logic [3:0] c_reqSltu = 4'd3;
    localparam logic [3:0] c_reqSub  = 4'd4;
    localparam logic [3:0] c_reqSlli = 4'd5;
    localparam logic [3:0] c_reqAddi = 4'd6;
    localparam logic [3:0] c_reqLui  = 4'd7;
    localparam logic [3:0] c_reqBeq  = 4'd8;
    localparam logic [3:0] c_reqBne  = 4'd9;

    // RV32I major opcodes
    localparam logic [6:0] c_opReg    = 7'b0110011;
    localparam logic [6:0] c_opImm    = 7'b0010011;
    localparam logic [6:0] c_opLui    = 7'b0110111;
    localparam logic [6:0] c_opBranch = 7'b1100011;

    localparam logic [ADDR_WIDTH-1:0] c_baseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_lastAddr = '1;

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic [ADDR_WIDTH-1:0] r_writePtr;
    logic [31:0]           w_word;
    logic                  w_legal;
    logic                  w_restart;
    logic                  w_xfer;
    logic                  w_write;
    logic                  w_atLastAddr;

    // A start pulse is only honoured outside RUN
    assign w_restart    = start && (r_state != c_run);
    assign w_xfer       = req_valid && (r_state == c_run);
    assign w_write      = w_xfer && w_legal;
    assign w_atLastAddr = (r_writePtr == c_lastAddr);

    // Instruction encoder: each op builds its word from its own layout only
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (req_op)
            c_reqAdd:  w_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, c_opReg};
            c_reqSub:  w_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, c_opReg};
            c_reqOr:   w_word = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, c_opReg};
            c_reqSrl:  w_word = {7'b0000000, req_rs2, req_rs1, 3'b101, req_rd, c_opReg};
            c_reqSltu: w_word = {7'b0000000, req_rs2, req_rs1, 3'b011, req_rd, c_opReg};
            c_reqSlli: w_word = {7'b0000000, req_imm[4:0], req_rs1, 3'b001, req_rd, c_opImm};
            c_reqAddi: w_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, c_opImm};
            c_reqLui:  w_word = {req_imm[31:12], req_rd, c_opLui};
            c_reqBeq:  w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                                 req_imm[4:1], req_imm[11], c_opBranch};
            c_reqBne:  w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                                 req_imm[4:1], req_imm[11], c_opBranch};
            default:   w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; req_last takes precedence over overflow at the final address
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_run: begin
                if (w_xfer) begin
                    if (!w_legal) begin
                        w_nextState = c_err;
                    end else if (req_last) begin
                        w_nextState = c_done;
                    end else if (w_atLastAddr) begin
                        w_nextState = c_err;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_nextState = c_run;
                end
            end
        endcase
    end

    // Status outputs decoded from state alone
    always_comb begin
        req_ready = (r_state == c_run);
        busy      = (r_state == c_run);
        done      = (r_state == c_done);
    end

    // Write pointer, word count and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_writePtr   <= c_baseAddr;
            count        <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (w_restart) begin
            r_writePtr   <= c_baseAddr;
            count        <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (w_xfer) begin
            if (!w_legal) begin
                err_illegal <= 1'b1;
            end else begin
                r_writePtr <= r_writePtr + 1'b1;
                count      <= count + 1'b1;
                if (!req_last && w_atLastAddr) begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end

    // Registered imem write port; address and data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= w_write;
            if (w_write) begin
                imem_addr  <= r_writePtr;
                imem_wdata <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_instr_encoder
//  Purpose  : Self-checking bench for sr_instr_encoder: directed scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sr_instr_encoder;

    localparam int AW   = 3;
    localparam int BASE = 0;
    localparam int CAP  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          req_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err_illegal;
    logic          err_overflow;
    logic [AW:0]   count;

    int nChecks = 0;
    int nErrors = 0;

    // Behavioural model state
    bit        mRun;
    bit        mDone;
    bit        mIll;
    bit        mOvf;
    int        mPtr;
    int        mCount;
    bit        mWe;
    bit [31:0] mAddr;
    bit [31:0] mData;

    sr_instr_encoder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .req_last     (req_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // RV32I encoding built from field positions with plain shifts
    function automatic bit [31:0] refEncode(input int op, input bit [31:0] rd, input bit [31:0] rs1,
                                            input bit [31:0] rs2, input bit [31:0] imm);
        bit [31:0] f3;
        bit [31:0] f7;
        bit [31:0] w;
        w = 0;
        case (op)
            0, 1, 2, 3, 4: begin
                f3 = (op == 1) ? 6 : (op == 2) ? 5 : (op == 3) ? 3 : 0;
                f7 = (op == 4) ? 32 : 0;
                w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
            end
            5: w = 32'h13 | (rd << 7) | (1 << 12) | (rs1 << 15) | ((imm & 31) << 20);
            6: w = 32'h13 | (rd << 7) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
            7: w = 32'h37 | (rd << 7) | (imm & 32'hFFFFF000);
            8, 9: begin
                f3 = (op == 9) ? 1 : 0;
                w = 32'h63 | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8)
                  | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
            end
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic modelReset();
        mRun   = 0;
        mDone  = 0;
        mIll   = 0;
        mOvf   = 0;
        mPtr   = BASE;
        mCount = 0;
        mWe    = 0;
        mAddr  = 0;
        mData  = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic modelClock();
        mWe = 0;
        if (rst) begin
            modelReset();
            return;
        end
        if (!mRun) begin
            if (start) begin
                mRun   = 1;
                mDone  = 0;
                mIll   = 0;
                mOvf   = 0;
                mPtr   = BASE;
                mCount = 0;
            end
        end else if (req_valid) begin
            if (int'(req_op) > 9) begin
                mIll = 1;
                mRun = 0;
            end else begin
                mWe   = 1;
                mAddr = mPtr;
                mData = refEncode(int'(req_op), req_rd, req_rs1, req_rs2, req_imm);
                mCount++;
                if (req_last) begin
                    mRun  = 0;
                    mDone = 1;
                end else if (mPtr == CAP - 1) begin
                    mOvf = 1;
                    mRun = 0;
                end
                mPtr = (mPtr + 1) % CAP;
            end
        end
    endtask

    task automatic checkAll();
        checkVal("imem_we", imem_we, mWe);
        checkVal("imem_addr", imem_addr, mAddr);
        checkVal("imem_wdata", imem_wdata, mData);
        checkVal("busy", busy, mRun);
        checkVal("done", done, mDone);
        checkVal("req_ready", req_ready, mRun);
        checkVal("err_illegal", err_illegal, mIll);
        checkVal("err_overflow", err_overflow, mOvf);
        checkVal("count", count, 32'(mCount));
    endtask

    // Drive one cycle of inputs (called just after a falling edge), then check
    task automatic drive(input bit st, input bit v, input int op, input int rd, input int rs1,
                         input int rs2, input bit [31:0] imm, input bit last);
        start     = st;
        req_valid = v;
        req_op    = 4'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
        req_last  = last;
        @(posedge clk);
        modelClock();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse raised between clock edges
    task automatic pulseReset();
        start     = 0;
        req_valid = 0;
        rst       = 1;
        #1;
        checkVal("rst_async_we", imem_we, 0);
        checkVal("rst_async_busy", busy, 0);
        @(posedge clk);
        modelClock();
        @(negedge clk);
        rst = 0;
        checkAll();
    endtask

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("reset_count", count, 0);
        checkVal("reset_ready", req_ready, 0);
        rst = 0;
        idle();

        // Single ADDI write one cycle after the transfer
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 6, 1, 0, 0, 32'd5, 0);
        checkVal("addi_we", imem_we, 1);
        checkVal("addi_addr", imem_addr, 0);
        checkVal("addi_word", imem_wdata, 32'h00500093);
        checkVal("addi_count", count, 1);

        // Reset while imem_we is high aborts the load
        pulseReset();
        checkVal("post_rst_count", count, 0);
        idle();

        // Back-to-back R-type and SLLI ending in DONE
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 3, 1, 2, 32'hFFFF_FFFF, 0);
        checkVal("add_word", imem_wdata, 32'h002081B3);
        drive(0, 1, 4, 3, 1, 2, 32'h0, 0);
        checkVal("sub_word", imem_wdata, 32'h402081B3);
        checkVal("sub_addr", imem_addr, 1);
        drive(0, 1, 5, 4, 4, 31, 32'hFFFF_FFE3, 1);
        checkVal("slli_word", imem_wdata, 32'h00321213);
        checkVal("slli_addr", imem_addr, 2);
        checkVal("done_flag", done, 1);
        checkVal("done_ready", req_ready, 0);
        checkVal("done_count", count, 3);
        drive(0, 1, 0, 1, 1, 1, 0, 0);
        checkVal("done_no_write", imem_we, 0);

        // LUI and branch encodings
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 7, 5, 9, 9, 32'h12345ABC, 0);
        checkVal("lui_word", imem_wdata, 32'h123452B7);
        drive(0, 1, 8, 7, 1, 2, 32'hFFFFFFFC, 0);
        checkVal("beq_word", imem_wdata, 32'hFE208EE3);
        drive(0, 1, 9, 7, 1, 2, 32'hFFFFFFFD, 1);
        checkVal("bne_word", imem_wdata, 32'hFE209EE3);

        // Illegal op after two legal requests
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 2, 3, 0, 0);
        drive(0, 1, 6, 2, 0, 0, 32'd7, 0);
        drive(0, 1, 12, 1, 1, 1, 0, 0);
        checkVal("illegal_flag", err_illegal, 1);
        checkVal("illegal_no_write", imem_we, 0);
        checkVal("illegal_count", count, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("restart_clears_ill", err_illegal, 0);
        drive(0, 1, 6, 1, 0, 0, 32'd5, 0);
        checkVal("restart_addr", imem_addr, 0);
        // start during RUN is ignored; the transfer lands at the next address
        drive(1, 1, 0, 3, 1, 2, 0, 1);
        checkVal("start_in_run_addr", imem_addr, 1);
        checkVal("start_in_run_count", count, 2);

        // Overflow: fill every address without req_last
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CAP; i++) begin
            drive(0, 1, 6, i + 1, 0, 0, 32'(i), 0);
        end
        checkVal("ovf_flag", err_overflow, 1);
        checkVal("ovf_last_addr", imem_addr, CAP - 1);
        checkVal("ovf_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 1, 1, 0, 0);
            checkVal("ovf_no_accept", imem_we, 0);
        end

        // req_last on the final address finishes cleanly
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CAP; i++) begin
            drive(0, 1, 1, 2, 3, 4, 0, (i == CAP - 1));
        end
        checkVal("last_at_end_done", done, 1);
        checkVal("last_at_end_ovf", err_overflow, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulseReset();
            end else begin
                int op;
                op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 15))
                                                  : int'($urandom_range(0, 9));
                drive($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, op,
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), $urandom(), $urandom_range(0, 7) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
